hsfir_cheap_mc: RTL and testbench

Parametrised, multichannel successor to the cheap half-band FIR. It filters a time-division-multiplexed stream of signed samples with the fixed 7-tap half-band kernel h = [-1, 0, 9, 16, 9, 0, -1]/32. Each channel has its own delay line, and the block has an optional decimate-by-2 mode. It sits between the sample source and the downstream rate-reduction or DSP stage, and is verified with the same driver/monitor clocking-block bench style as its predecessor.

---
 rtl/hsfir_cheap_mc.sv | 162 ++++++++++++++++
 tb/tb_hsfir_cheap_mc.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hsfir_cheap_mc.sv
// Multichannel 7-tap half-band FIR, h = [-1 0 9 16 9 0 -1]/32, with per-channel
// delay lines and an optional decimate-by-2 that gates which samples produce outputs.
module hsfir_cheap_mc #(
    parameter int DATA_W   = 8,
    parameter int CHANNELS = 1,
    parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic signed [DATA_W-1:0] data_in,
    input  logic                     in_valid,
    input  logic        [CH_W-1:0]   ch_in,
    input  logic                     decim_en,
    output logic signed [DATA_W-1:0] data_out,
    output logic                     out_valid,
    output logic        [CH_W-1:0]   ch_out
);

    localparam int AW = DATA_W + 6;
    localparam int SW = DATA_W + 1;
    localparam logic signed [AW-1:0] SAT_MAX = AW'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [AW-1:0] SAT_MIN = ~SAT_MAX;
    localparam logic signed [AW-1:0] ROUND   = AW'(16);

    logic                     w_accept;
    logic                     w_emit;
    logic [CH_W-1:0]          w_ch;
    logic [CHANNELS-1:0]      r_phase;
    logic                     r_decimEn;

    logic                     r_inAccept;
    logic                     r_inEmit;
    logic [CH_W-1:0]          r_inCh;
    logic signed [DATA_W-1:0] r_inData;

    logic signed [DATA_W-1:0] r_line [CHANNELS][6];
    logic signed [DATA_W-1:0] w_d2;
    logic signed [DATA_W-1:0] w_d3;
    logic signed [DATA_W-1:0] w_d4;
    logic signed [DATA_W-1:0] w_d6;
    logic signed [SW-1:0]     w_outer;
    logic signed [SW-1:0]     w_inner;

    logic                     r_s1Valid;
    logic [CH_W-1:0]          r_s1Ch;
    logic signed [SW-1:0]     r_s1Outer;
    logic signed [SW-1:0]     r_s1Inner;
    logic signed [DATA_W-1:0] r_s1Mid;

    logic signed [AW-1:0]     w_outerX;
    logic signed [AW-1:0]     w_innerX;
    logic signed [AW-1:0]     w_midX;
    logic signed [AW-1:0]     w_acc;
    logic signed [AW-1:0]     w_sum;
    logic signed [AW-1:0]     w_shift;
    logic signed [DATA_W-1:0] w_sat;

    // Emit decision and phase bookkeeping happen at acceptance; the data path follows later.
    assign w_accept = in_valid && (32'(ch_in) < CHANNELS);
    assign w_ch     = w_accept ? ch_in : '0;
    assign w_emit   = w_accept && (!decim_en || !r_phase[w_ch]);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_phase   <= '0;
            r_decimEn <= 1'b0;
        end else begin
            r_decimEn <= decim_en;
            if (decim_en != r_decimEn) begin
                r_phase <= '0;
            end else if (w_accept) begin
                r_phase[w_ch] <= ~r_phase[w_ch];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_inAccept <= 1'b0;
            r_inEmit   <= 1'b0;
            r_inCh     <= '0;
            r_inData   <= '0;
        end else begin
            r_inAccept <= w_accept;
            r_inEmit   <= w_emit;
            r_inCh     <= w_ch;
            r_inData   <= data_in;
        end
    end

    // The line is read and shifted on the same edge, so a back-to-back sample on the
    // same channel always sees every earlier write without a separate bypass.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int c = 0; c < CHANNELS; c++) begin
                for (int k = 0; k < 6; k++) begin
                    r_line[c][k] <= '0;
                end
            end
        end else if (r_inAccept) begin
            for (int k = 5; k > 0; k--) begin
                r_line[r_inCh][k] <= r_line[r_inCh][k-1];
            end
            r_line[r_inCh][0] <= r_inData;
        end
    end

    assign w_d2    = r_line[r_inCh][1];
    assign w_d3    = r_line[r_inCh][2];
    assign w_d4    = r_line[r_inCh][3];
    assign w_d6    = r_line[r_inCh][5];
    assign w_outer = {r_inData[DATA_W-1], r_inData} + {w_d6[DATA_W-1], w_d6};
    assign w_inner = {w_d2[DATA_W-1], w_d2} + {w_d4[DATA_W-1], w_d4};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_s1Valid <= 1'b0;
            r_s1Ch    <= '0;
            r_s1Outer <= '0;
            r_s1Inner <= '0;
            r_s1Mid   <= '0;
        end else begin
            r_s1Valid <= r_inEmit;
            r_s1Ch    <= r_inCh;
            r_s1Outer <= w_outer;
            r_s1Inner <= w_inner;
            r_s1Mid   <= w_d3;
        end
    end

    // 9*a = (a<<3)+a and 16*b = b<<4; the accumulator is wide enough that no sum wraps.
    assign w_outerX = {{(AW-SW){r_s1Outer[SW-1]}}, r_s1Outer};
    assign w_innerX = {{(AW-SW){r_s1Inner[SW-1]}}, r_s1Inner};
    assign w_midX   = {{(AW-DATA_W){r_s1Mid[DATA_W-1]}}, r_s1Mid};
    assign w_acc    = (w_innerX <<< 3) + w_innerX + (w_midX <<< 4) - w_outerX;
    assign w_sum    = w_acc + ROUND;
    assign w_shift  = w_sum >>> 5;

    always_comb begin
        w_sat = w_shift[DATA_W-1:0];
        if (w_shift > SAT_MAX) begin
            w_sat = SAT_MAX[DATA_W-1:0];
        end else if (w_shift < SAT_MIN) begin
            w_sat = SAT_MIN[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            data_out  <= '0;
            ch_out    <= '0;
        end else begin
            out_valid <= r_s1Valid;
            if (r_s1Valid) begin
                data_out <= w_sat;
                ch_out   <= r_s1Ch;
            end
        end
    end

endmodule

// File: tb/tb_hsfir_cheap_mc.sv
// Bench for hsfir_cheap_mc: a per-channel arithmetic model predicts every output beat,
// and directed scenarios are additionally pinned to hand-computed values.
module tb_hsfir_cheap_mc;

    localparam int DW  = 8;
    localparam int NCH = 3;
    localparam int CW  = 2;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic signed [DW-1:0] data_in;
    logic                 in_valid;
    logic [CW-1:0]        ch_in;
    logic                 decim_en;
    logic signed [DW-1:0] data_out;
    logic                 out_valid;
    logic [CW-1:0]        ch_out;

    always #5 clk = ~clk;

    hsfir_cheap_mc #(
        .DATA_W   (DW),
        .CHANNELS (NCH)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .data_in   (data_in),
        .in_valid  (in_valid),
        .ch_in     (ch_in),
        .decim_en  (decim_en),
        .data_out  (data_out),
        .out_valid (out_valid),
        .ch_out    (ch_out)
    );

    typedef struct {
        int due;
        int ch;
        int val;
    } exp_t;

    exp_t expQ[$];
    int   hist [NCH][6];
    bit   phase [NCH];
    bit   decimReg;
    bit   lastReset;
    int   edgeNo = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   obsData[$];
    int   obsCh[$];
    int   ch0Obs[$];
    int   ch1Obs[$];
    int   impLit[8] = '{-2, 0, 18, 32, 18, 0, -2, 0};
    int   decLit[4] = '{0, 0, 8, 16};

    function automatic int quant(int acc);
        int r;
        r = (acc + 16) >>> 5;
        if (r > 127) r = 127;
        if (r < -128) r = -128;
        return r;
    endfunction

    function automatic int getObs(int i);
        return (i < obsData.size()) ? obsData[i] : -9999;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit v, input int ch, input int d);
        @(negedge clk);
        in_valid = v;
        ch_in    = CW'(ch);
        data_in  = DW'(d);
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 0, 0);
    endtask

    task automatic doReset(input int n);
        @(negedge clk);
        reset_n  = 1'b0;
        in_valid = 1'b1;
        ch_in    = '0;
        data_in  = DW'(55);
        repeat (n) @(negedge clk);
        reset_n  = 1'b1;
        in_valid = 1'b0;
    endtask

    task automatic setDecim(input bit v);
        @(negedge clk);
        decim_en = v;
        in_valid = 1'b0;
        idle(2);
    endtask

    // Reference model: y = -x + 9*d2 + 16*d3 + 9*d4 - d6, due two edges after acceptance.
    initial forever begin
        @(posedge clk);
        edgeNo++;
        if (!reset_n) begin
            lastReset = 1'b1;
            expQ.delete();
            decimReg = 1'b0;
            for (int c = 0; c < NCH; c++) begin
                phase[c] = 1'b0;
                for (int k = 0; k < 6; k++) hist[c][k] = 0;
            end
        end else begin
            lastReset = 1'b0;
            if (in_valid && int'(ch_in) < NCH) begin
                int c;
                int x;
                int y;
                c = int'(ch_in);
                x = int'(data_in);
                y = quant(-x + 9 * hist[c][1] + 16 * hist[c][2] + 9 * hist[c][3] - hist[c][5]);
                if (!decim_en || !phase[c]) expQ.push_back('{due: edgeNo + 2, ch: c, val: y});
                for (int k = 5; k > 0; k--) hist[c][k] = hist[c][k-1];
                hist[c][0] = x;
                phase[c] = !phase[c];
            end
            if (decim_en != decimReg) begin
                for (int c = 0; c < NCH; c++) phase[c] = 1'b0;
            end
            decimReg = decim_en;
        end
    end

    initial forever begin
        @(negedge clk);
        if (edgeNo > 0) begin
            if (out_valid) begin
                obsData.push_back(int'(data_out));
                obsCh.push_back(int'(ch_out));
            end
            if (lastReset) begin
                checkOutput("reset_valid", int'(out_valid), 0);
                checkOutput("reset_data", int'(data_out), 0);
                checkOutput("reset_ch", int'(ch_out), 0);
            end else if (expQ.size() > 0 && expQ[0].due == edgeNo) begin
                checkOutput("out_valid", int'(out_valid), 1);
                checkOutput("ch_out", int'(ch_out), expQ[0].ch);
                checkOutput("data_out", int'(data_out), expQ[0].val);
                void'(expQ.pop_front());
            end else begin
                checkOutput("idle_valid", int'(out_valid), 0);
            end
        end
    end

    initial begin
        reset_n  = 1'b0;
        in_valid = 1'b0;
        ch_in    = '0;
        data_in  = '0;
        decim_en = 1'b0;
        doReset(3);

        $display("[TB] impulse");
        obsData.delete(); obsCh.delete();
        applyStimulus(1'b1, 0, 64);
        repeat (10) applyStimulus(1'b1, 0, 0);
        idle(4);
        checkOutput("impulse_count", obsData.size(), 11);
        for (int i = 0; i < 8; i++) checkOutput($sformatf("impulse[%0d]", i), getObs(i), impLit[i]);

        $display("[TB] step with saturation");
        obsData.delete(); obsCh.delete();
        repeat (16) applyStimulus(1'b1, 0, -128);
        repeat (12) applyStimulus(1'b1, 0, 127);
        idle(4);
        checkOutput("step_count", obsData.size(), 28);
        checkOutput("step_low_steady", getObs(15), -128);
        checkOutput("step_first_clip", getObs(16), -128);
        checkOutput("step_mid_a", getObs(18), -64);
        checkOutput("step_mid_b", getObs(19), 63);
        checkOutput("step_high_clip", getObs(20), 127);
        checkOutput("step_high_steady", getObs(27), 127);

        $display("[TB] nyquist and dc");
        obsData.delete(); obsCh.delete();
        for (int i = 0; i < 14; i++) applyStimulus(1'b1, 0, (i % 2 == 0) ? 100 : -100);
        repeat (10) applyStimulus(1'b1, 0, 100);
        idle(4);
        checkOutput("nyquist_a", getObs(12), 0);
        checkOutput("nyquist_b", getObs(13), 0);
        checkOutput("dc_steady", getObs(23), 100);

        $display("[TB] tdm independence");
        doReset(1);
        obsData.delete(); obsCh.delete();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 0, (i == 0) ? 64 : 0);
            applyStimulus(1'b1, 1, 32);
            if (i == 4) applyStimulus(1'b1, 3, 127);
        end
        idle(4);
        ch0Obs.delete(); ch1Obs.delete();
        for (int i = 0; i < obsCh.size(); i++) begin
            if (obsCh[i] == 0) ch0Obs.push_back(obsData[i]);
            else if (obsCh[i] == 1) ch1Obs.push_back(obsData[i]);
        end
        checkOutput("tdm_total", obsData.size(), 20);
        checkOutput("tdm_ch0_count", ch0Obs.size(), 10);
        checkOutput("tdm_ch1_count", ch1Obs.size(), 10);
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("tdm_ch0[%0d]", i), (i < ch0Obs.size()) ? ch0Obs[i] : -9999, impLit[i]);
        end
        checkOutput("tdm_ch1_first", (ch1Obs.size() > 0) ? ch1Obs[0] : -9999, -1);
        checkOutput("tdm_ch1_steady", (ch1Obs.size() == 10) ? ch1Obs[9] : -9999, 32);

        $display("[TB] decimation");
        setDecim(1'b1);
        obsData.delete(); obsCh.delete();
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 0, 8 * i);
        idle(3);
        setDecim(1'b0);
        setDecim(1'b1);
        applyStimulus(1'b1, 0, 40);
        idle(4);
        checkOutput("decim_count", obsData.size(), 4);
        for (int i = 0; i < 4; i++) checkOutput($sformatf("decim[%0d]", i), getObs(i), decLit[i]);

        $display("[TB] reset mid-stream");
        setDecim(1'b0);
        obsData.delete(); obsCh.delete();
        applyStimulus(1'b1, 0, 100);
        applyStimulus(1'b1, 0, 100);
        doReset(1);
        applyStimulus(1'b1, 0, 64);
        repeat (8) applyStimulus(1'b1, 0, 0);
        idle(4);
        checkOutput("midreset_count", obsData.size(), 9);
        checkOutput("midreset_first", getObs(0), -2);
        checkOutput("midreset_third", getObs(2), 18);

        idle(2);
        checkOutput("drain_pending", expQ.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
